// File: rtl/busctl.sv
// 8085-style bus control: strobes, ALE, AD/high-address pads and read capture.
// Optional wait-state timeout counter enabled by BUSCTL_WAITCNT_EN.
module busctl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16,
    parameter int WAITMAX  = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   nstate,
    input  logic [2:0]                   stat,
    input  logic                         bimc,
    input  logic [ADDRSIZE-1:0]          addr,
    input  logic [DATASIZE-1:0]          dout,
    input  logic [DATASIZE-1:0]          ad_in,
    output logic                         ale,
    output logic                         rd_,
    output logic                         wr_,
    output logic                         inta_,
    output logic [DATASIZE-1:0]          ad_out,
    output logic                         ad_oe,
    output logic [ADDRSIZE-DATASIZE-1:0] a_hi,
    output logic                         a_oe,
    output logic [DATASIZE-1:0]          din,
    output logic                         dvalid,
    output logic                         bus_tmo
);

    localparam logic [3:0] TR = 4'b0000;
    localparam logic [3:0] T1 = 4'b0001;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T3 = 4'b0011;
    localparam logic [3:0] T4 = 4'b0100;
    localparam logic [3:0] T5 = 4'b0101;
    localparam logic [3:0] T6 = 4'b0110;
    localparam logic [3:0] TW = 4'b1000;

    logic [3:0] tq;
    logic [2:0] stat_q;
    logic       bimc_q;

    logic is_inta;
    logic is_rd;
    logic is_wr;
    logic cap;

    assign is_inta = (stat_q == 3'b111);
    assign is_rd   = stat_q[1] && !is_inta;
    assign is_wr   = (stat_q[1:0] == 2'b01);
    // INTA data is captured like a read (opcode from the interrupting device)
    assign cap     = (tq == T3) && stat_q[1] && !bimc_q;

    logic                         n_ale;
    logic                         n_rd;
    logic                         n_wr;
    logic                         n_inta;
    logic                         n_ad_oe;
    logic                         n_a_oe;
    logic [DATASIZE-1:0]          n_ad_out;
    logic [ADDRSIZE-DATASIZE-1:0] n_a_hi;

    always_comb begin
        n_ale    = 1'b0;
        n_rd     = 1'b1;
        n_wr     = 1'b1;
        n_inta   = 1'b1;
        n_ad_oe  = 1'b0;
        n_a_oe   = 1'b0;
        n_ad_out = ad_out;
        n_a_hi   = a_hi;
        unique case (nstate)
            T1: begin
                n_ale    = ~bimc;
                n_ad_out = addr[DATASIZE-1:0];
                n_a_hi   = addr[ADDRSIZE-1:DATASIZE];
                n_ad_oe  = 1'b1;
                n_a_oe   = 1'b1;
            end
            T2, TW, T3: begin
                n_a_oe = 1'b1;
                if (!bimc_q) begin
                    n_rd   = ~is_rd;
                    n_wr   = ~is_wr;
                    n_inta = ~is_inta;
                    if (is_wr) begin
                        n_ad_out = dout;
                        n_ad_oe  = 1'b1;
                    end
                end
            end
            T4, T5, T6: begin
                n_a_oe = 1'b1;
            end
            default: begin
                n_a_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tq     <= TR;
            stat_q <= 3'b000;
            bimc_q <= 1'b0;
            ale    <= 1'b0;
            rd_    <= 1'b1;
            wr_    <= 1'b1;
            inta_  <= 1'b1;
            ad_out <= '0;
            ad_oe  <= 1'b0;
            a_hi   <= '0;
            a_oe   <= 1'b0;
            din    <= '0;
            dvalid <= 1'b0;
        end else begin
            tq     <= nstate;
            if (nstate == T1) begin
                stat_q <= stat;
                bimc_q <= bimc;
            end
            ale    <= n_ale;
            rd_    <= n_rd;
            wr_    <= n_wr;
            inta_  <= n_inta;
            ad_out <= n_ad_out;
            ad_oe  <= n_ad_oe;
            a_hi   <= n_a_hi;
            a_oe   <= n_a_oe;
            dvalid <= cap;
            if (cap) begin
                din <= ad_in;
            end
        end
    end

`ifdef BUSCTL_WAITCNT_EN
    localparam logic [8:0] WMAX = 9'(WAITMAX);

    logic [7:0] wcnt;
    logic [8:0] wcnt_inc;

    assign wcnt_inc = {1'b0, wcnt} + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt    <= 8'd0;
            bus_tmo <= 1'b0;
        end else begin
            if (tq != TW) begin
                wcnt <= 8'd0;
            end else if (wcnt != 8'hFF) begin
                wcnt <= wcnt_inc[7:0];
            end
            // sticky until the next machine cycle starts
            if (nstate == T1) begin
                bus_tmo <= 1'b0;
            end else if (tq == TW && wcnt_inc >= WMAX) begin
                bus_tmo <= 1'b1;
            end
        end
    end
`else
    assign bus_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_busctl.sv
// Directed-vector bench for busctl: read, write with waits, INTA, idle cycle,
// mid-cycle reset, bus release on undefined codes and wait timeout.
module tb_busctl;

    localparam logic [3:0] TR = 4'b0000;
    localparam logic [3:0] T1 = 4'b0001;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T3 = 4'b0011;
    localparam logic [3:0] T4 = 4'b0100;
    localparam logic [3:0] TW = 4'b1000;

`ifdef BUSCTL_WAITCNT_EN
    localparam logic TMO_EXP = 1'b1;
`else
    localparam logic TMO_EXP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  nstate;
    logic [2:0]  stat;
    logic        bimc;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [7:0]  ad_in;
    logic        ale;
    logic        rd_;
    logic        wr_;
    logic        inta_;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  a_hi;
    logic        a_oe;
    logic [7:0]  din;
    logic        dvalid;
    logic        bus_tmo;

    int nvec;
    int nerr;
    logic tmo_exp_v;

    busctl #(.DATASIZE(8), .ADDRSIZE(16), .WAITMAX(3)) dut (
        .clk(clk), .rst(rst), .nstate(nstate), .stat(stat), .bimc(bimc),
        .addr(addr), .dout(dout), .ad_in(ad_in), .ale(ale), .rd_(rd_),
        .wr_(wr_), .inta_(inta_), .ad_out(ad_out), .ad_oe(ad_oe),
        .a_hi(a_hi), .a_oe(a_oe), .din(din), .dvalid(dvalid),
        .bus_tmo(bus_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // present nstate, let one edge register it, sample just after
    task automatic cyc(input logic [3:0] ns);
        nstate = ns;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        tmo_exp_v = TMO_EXP;
        rst = 1'b1;
        nstate = TR;
        stat = 3'b000;
        bimc = 1'b0;
        addr = 16'h0000;
        dout = 8'h00;
        ad_in = 8'h00;
        cyc(TR);
        cyc(TR);
        chk("rst_ale", ale, 0);
        chk("rst_strb", {rd_, wr_, inta_}, 3'b111);
        chk("rst_oe", {ad_oe, a_oe}, 2'b00);
        chk("rst_ad", {a_hi, ad_out}, 16'h0000);
        chk("rst_din", din, 8'h00);
        chk("rst_dv", dvalid, 0);
        chk("rst_tmo", bus_tmo, 0);
        rst = 1'b0;
        cyc(TR);

        // memory read
        stat = 3'b010; addr = 16'h2050; ad_in = 8'hA5;
        cyc(T1);
        chk("rd_t1_ale", ale, 1);
        chk("rd_t1_addr", {a_hi, ad_out}, 16'h2050);
        chk("rd_t1_oe", {ad_oe, a_oe}, 2'b11);
        chk("rd_t1_strb", {rd_, wr_, inta_}, 3'b111);
        cyc(T2);
        chk("rd_t2_ale", ale, 0);
        chk("rd_t2_strb", {rd_, wr_, inta_}, 3'b011);
        chk("rd_t2_oe", {ad_oe, a_oe}, 2'b01);
        cyc(T3);
        chk("rd_t3_strb", {rd_, wr_, inta_}, 3'b011);
        chk("rd_t3_dv", dvalid, 0);
        cyc(T4);
        chk("rd_t4_strb", {rd_, wr_, inta_}, 3'b111);
        chk("rd_t4_dv", dvalid, 1);
        chk("rd_t4_din", din, 8'hA5);
        chk("rd_t4_oe", {ad_oe, a_oe, a_hi}, 10'b01_0010_0000);
        cyc(TR);
        chk("rd_tr_dv", dvalid, 0);
        chk("rd_tr_oe", {ad_oe, a_oe}, 2'b00);

        // memory write with two waits
        stat = 3'b001; addr = 16'h8001; dout = 8'h3C;
        cyc(T1);
        chk("wr_t1_addr", {a_hi, ad_out}, 16'h8001);
        cyc(T2);
        chk("wr_t2_strb", {rd_, wr_, inta_}, 3'b101);
        chk("wr_t2_ad", {ad_oe, ad_out}, 9'h13C);
        cyc(TW);
        chk("wr_w1_strb", {rd_, wr_, inta_}, 3'b101);
        chk("wr_w1_ad", {ad_oe, ad_out}, 9'h13C);
        cyc(TW);
        chk("wr_w2_strb", {rd_, wr_, inta_}, 3'b101);
        cyc(T3);
        chk("wr_t3_strb", {rd_, wr_, inta_}, 3'b101);
        chk("wr_t3_ad", {ad_oe, ad_out}, 9'h13C);
        cyc(T4);
        chk("wr_t4_strb", {rd_, wr_, inta_}, 3'b111);
        chk("wr_t4_dv", dvalid, 0);
        cyc(TR);

        // INTA with status disturbed after T1
        stat = 3'b111; addr = 16'h1234; ad_in = 8'hC7;
        cyc(T1);
        stat = 3'b010;
        cyc(T2);
        chk("ia_t2_strb", {rd_, wr_, inta_}, 3'b110);
        chk("ia_t2_oe", ad_oe, 0);
        cyc(T3);
        chk("ia_t3_strb", {rd_, wr_, inta_}, 3'b110);
        cyc(T4);
        chk("ia_t4_dv", {dvalid, din}, 9'h1C7);
        cyc(TR);

        // bus idle machine cycle
        bimc = 1'b1; stat = 3'b010; ad_in = 8'h11;
        cyc(T1);
        chk("bi_t1_ale", ale, 0);
        bimc = 1'b0;
        cyc(T2);
        chk("bi_t2_strb", {rd_, wr_, inta_}, 3'b111);
        cyc(T3);
        chk("bi_t3_strb", {rd_, wr_, inta_}, 3'b111);
        cyc(T4);
        chk("bi_t4_dv", {dvalid, din}, 9'h0C7);
        cyc(TR);

        // reset mid-read
        stat = 3'b010; addr = 16'h4000; ad_in = 8'h77;
        cyc(T1);
        cyc(T2);
        chk("mr_t2_rd", rd_, 0);
        rst = 1'b1;
        cyc(T3);
        chk("mr_strb", {ale, rd_, wr_, inta_}, 4'b0111);
        chk("mr_oe", {ad_oe, a_oe}, 2'b00);
        chk("mr_dv", {dvalid, din}, 9'h000);
        rst = 1'b0;
        cyc(TR);

        // undefined state code releases the bus
        stat = 3'b001; addr = 16'h5566;
        cyc(T1);
        cyc(4'b1010);
        chk("ud_strb", {ale, rd_, wr_, inta_}, 4'b0111);
        chk("ud_oe", {ad_oe, a_oe}, 2'b00);
        cyc(TR);

        // wait timeout: four TW clocks
        stat = 3'b010; addr = 16'h0102;
        cyc(T1);
        cyc(T2);
        chk("wt_t2_tmo", bus_tmo, 0);
        cyc(TW);
        cyc(TW);
        cyc(TW);
        cyc(TW);
        cyc(T3);
        chk("wt_t3_tmo", bus_tmo, tmo_exp_v);
        cyc(T4);
        chk("wt_t4_tmo", bus_tmo, tmo_exp_v);
        cyc(TR);
        cyc(T1);
        chk("wt_t1_clr", bus_tmo, 0);
        cyc(TR);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
